// File: rtl/aer_rr_scheduler_pkg.sv
// Shared types and helpers for the address-event round-robin scheduler.
package aer_pkg;

  typedef enum logic [1:0] {IDLE, SEND, RETURN} aer_state_t;

  localparam int unsigned DEFAULT_N = 32;

  function automatic int unsigned addr_w(input int unsigned n);
    return $clog2(n);
  endfunction

endpackage

// File: rtl/aer_rr_scheduler_rr_pick.sv
// Round-robin pick: first set request at or after ptr, wrapping to index 0.
module rr_pick
  import aer_pkg::*;
#(
  parameter int unsigned N      = DEFAULT_N,
  parameter int unsigned ADDR_W = addr_w(N)
) (
  input  logic [N-1:0]      req,
  input  logic [ADDR_W-1:0] ptr,
  output logic              valid,
  output logic [ADDR_W-1:0] idx
);

  logic [2*N-1:0] dbl;

  // Lower copy keeps only bits at/above ptr; upper copy supplies the wrap.
  always_comb begin
    dbl = {req, req};
    for (int unsigned i = 0; i < N; i++) begin
      if (i < 32'(ptr)) dbl[i] = 1'b0;
    end
  end

  always_comb begin
    valid = 1'b0;
    idx   = '0;
    for (int unsigned i = 0; i < 2*N; i++) begin
      if (!valid && dbl[i]) begin
        valid = 1'b1;
        idx   = (i >= N) ? ADDR_W'(i - N) : ADDR_W'(i);
      end
    end
  end

endmodule

// File: rtl/aer_rr_scheduler.sv
// Shares one bundled-data 4-phase address-event channel among N requesters,
// granting round-robin and acking the winner after the output handshake.
module aer_rr_scheduler
  import aer_pkg::*;
#(
  parameter int unsigned N           = DEFAULT_N,
  parameter int unsigned ADDR_W      = addr_w(N),
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N-1:0]      req_in,
  output logic [N-1:0]      ack_in,
  output logic              out_req,
  output logic [ADDR_W-1:0] out_addr,
  input  logic              out_ack,
  output logic              busy
);

  logic [SYNC_STAGES-1:0][N-1:0] req_sync;
  logic [SYNC_STAGES-1:0]        ack_sync;
  logic [N-1:0]                  req_s;
  logic                          ack_s;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_sync <= '0;
      ack_sync <= '0;
    end else begin
      req_sync <= {req_sync[SYNC_STAGES-2:0], req_in};
      ack_sync <= {ack_sync[SYNC_STAGES-2:0], out_ack};
    end
  end

  assign req_s = req_sync[SYNC_STAGES-1];
  assign ack_s = ack_sync[SYNC_STAGES-1];

  aer_state_t        state, state_n;
  logic [ADDR_W-1:0] ptr, ptr_n, addr_n;
  logic              req_n;
  logic [N-1:0]      ack_n;
  logic              pick_valid;
  logic [ADDR_W-1:0] pick_idx;

  rr_pick #(.N(N), .ADDR_W(ADDR_W)) u_pick (
    .req   (req_s),
    .ptr   (ptr),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      ptr      <= '0;
      out_addr <= '0;
      out_req  <= 1'b0;
      ack_in   <= '0;
    end else begin
      state    <= state_n;
      ptr      <= ptr_n;
      out_addr <= addr_n;
      out_req  <= req_n;
      ack_in   <= ack_n;
    end
  end

  // out_addr doubles as the winner register for the whole transaction.
  always_comb begin
    state_n = state;
    ptr_n   = ptr;
    addr_n  = out_addr;
    req_n   = out_req;
    ack_n   = ack_in;
    case (state)
      IDLE: begin
        if (pick_valid) begin
          addr_n  = pick_idx;
          req_n   = 1'b1;
          state_n = SEND;
        end
      end
      SEND: begin
        req_n = 1'b1;
        if (ack_s) begin
          req_n           = 1'b0;
          ack_n           = '0;
          ack_n[out_addr] = 1'b1;
          state_n         = RETURN;
        end
      end
      RETURN: begin
        if (!ack_s && !req_s[out_addr]) begin
          ack_n   = '0;
          ptr_n   = (out_addr == ADDR_W'(N - 1)) ? '0 : out_addr + ADDR_W'(1);
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_aer_rr_scheduler.sv
// Bench for aer_rr_scheduler: N=32 and N=5 instances with 4-phase agents.
module tb_aer_rr_scheduler;

  localparam int NA  = 32;
  localparam int NB  = 5;
  localparam int AWA = 5;
  localparam int AWB = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic [NA-1:0]  req_a = '0, ack_a;
  logic           oreq_a, oack_a = 1'b0, busy_a;
  logic [AWA-1:0] oaddr_a;
  logic [NB-1:0]  req_b = '0, ack_b;
  logic           oreq_b, oack_b = 1'b0, busy_b;
  logic [AWB-1:0] oaddr_b;

  always #5 clk = ~clk;

  aer_rr_scheduler #(.N(NA), .ADDR_W(AWA), .SYNC_STAGES(2)) dut_a (
    .clk(clk), .rst(rst), .req_in(req_a), .ack_in(ack_a), .out_req(oreq_a),
    .out_addr(oaddr_a), .out_ack(oack_a), .busy(busy_a));

  aer_rr_scheduler #(.N(NB), .ADDR_W(AWB), .SYNC_STAGES(2)) dut_b (
    .clk(clk), .rst(rst), .req_in(req_b), .ack_in(ack_b), .out_req(oreq_b),
    .out_addr(oaddr_b), .out_ack(oack_b), .busy(busy_b));

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input longint got, input longint exp);
    n_total++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, got, exp);
  endtask

  // Monitor: grant log (ack_in rising edges) and invariant violations.
  int             glog_a[$];
  int             glog_b[$];
  int             viol_a = 0, viol_b = 0;
  logic [NA-1:0]  pack_a = '0;
  logic [NB-1:0]  pack_b = '0;
  logic           poreq_a = 1'b0, poreq_b = 1'b0;
  logic [AWA-1:0] paddr_a = '0;
  logic [AWB-1:0] paddr_b = '0;

  always @(negedge clk) begin
    if (rst) begin
      pack_a = '0; poreq_a = 1'b0; paddr_a = '0;
      pack_b = '0; poreq_b = 1'b0; paddr_b = '0;
    end else begin
      if (!$onehot0(ack_a) || (oreq_a && |ack_a) ||
          (poreq_a && oreq_a && oaddr_a != paddr_a) || 32'(oaddr_a) >= NA) viol_a++;
      if (!$onehot0(ack_b) || (oreq_b && |ack_b) ||
          (poreq_b && oreq_b && oaddr_b != paddr_b) || 32'(oaddr_b) >= NB) viol_b++;
      for (int k = 0; k < NA; k++)
        if (ack_a[k] && !pack_a[k]) begin
          glog_a.push_back(k);
          if (k != int'(oaddr_a)) viol_a++;
        end
      for (int k = 0; k < NB; k++)
        if (ack_b[k] && !pack_b[k]) begin
          glog_b.push_back(k);
          if (k != int'(oaddr_b)) viol_b++;
        end
      pack_a = ack_a; poreq_a = oreq_a; paddr_a = oaddr_a;
      pack_b = ack_b; poreq_b = oreq_b; paddr_b = oaddr_b;
    end
  end

  // Environment agents: requesters with request credits, output responder.
  int            cred_a[NA];
  int            cred_b[NB];
  logic [NA-1:0] kill_a = '0;
  int            cnt_a = 0, cnt_b = 0;
  int            resp_dly = 3;

  task automatic cycle();
    @(negedge clk);
    if (!rst) begin
      for (int k = 0; k < NA; k++) begin
        if (req_a[k] && ack_a[k]) req_a[k] = 1'b0;
        else if (!req_a[k] && !ack_a[k] && cred_a[k] > 0) begin
          req_a[k] = 1'b1; cred_a[k]--;
        end
      end
      req_a = req_a & ~kill_a;
      for (int k = 0; k < NB; k++) begin
        if (req_b[k] && ack_b[k]) req_b[k] = 1'b0;
        else if (!req_b[k] && !ack_b[k] && cred_b[k] > 0) begin
          req_b[k] = 1'b1; cred_b[k]--;
        end
      end
      if (oack_a != oreq_a) begin
        cnt_a++;
        if (cnt_a >= resp_dly) begin oack_a = oreq_a; cnt_a = 0; end
      end else cnt_a = 0;
      if (oack_b != oreq_b) begin
        cnt_b++;
        if (cnt_b >= resp_dly) begin oack_b = oreq_b; cnt_b = 0; end
      end else cnt_b = 0;
    end
  endtask

  task automatic wait_grants(input int ta, input int tb_n, input int budget, input string name);
    bit done = 1'b0;
    for (int i = 0; i < budget && !done; i++) begin
      cycle();
      if (glog_a.size() >= ta && glog_b.size() >= tb_n) done = 1'b1;
    end
    check({name, "_grants_in_time"}, done, 1);
  endtask

  task automatic wait_idle(input int budget, input string name);
    int  quiet = 0;
    int  creds;
    bit  done = 1'b0;
    for (int i = 0; i < budget && !done; i++) begin
      cycle();
      creds = 0;
      for (int k = 0; k < NA; k++) creds += cred_a[k];
      for (int k = 0; k < NB; k++) creds += cred_b[k];
      if (!busy_a && !busy_b && req_a == '0 && req_b == '0 && ack_a == '0 &&
          ack_b == '0 && !oack_a && !oack_b && creds == 0) quiet++;
      else quiet = 0;
      if (quiet >= 4) done = 1'b1;
    end
    check({name, "_idle_in_time"}, done, 1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    req_a = '0; req_b = '0; oack_a = 1'b0; oack_b = 1'b0;
    kill_a = '0; cnt_a = 0; cnt_b = 0;
    for (int k = 0; k < NA; k++) cred_a[k] = 0;
    for (int k = 0; k < NB; k++) cred_b[k] = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  typedef struct {
    bit          do_reset;
    logic [31:0] mask;
    int          n;
    int          exp[4];
  } vec_t;

  vec_t tab[7];

  initial begin
    int            edges, base, base_b, dups, mptr, k;
    logic [31:0]   mask, pending;
    int            expq[$];
    bit [NA-1:0]   seen;

    tab[0] = '{1'b0, 32'h0000_0070, 3, '{6, 4, 5, 0}};   // ptr=6 after the req[5] test
    tab[1] = '{1'b1, 32'h0010_0408, 3, '{3, 10, 20, 0}};
    tab[2] = '{1'b0, 32'h0010_0008, 2, '{3, 20, 0, 0}};
    tab[3] = '{1'b0, 32'h8000_0000, 1, '{31, 0, 0, 0}};
    tab[4] = '{1'b0, 32'h8000_0001, 2, '{0, 31, 0, 0}};
    tab[5] = '{1'b0, 32'h0000_00C2, 3, '{1, 6, 7, 0}};
    tab[6] = '{1'b0, 32'h0000_0204, 2, '{9, 2, 0, 0}};
    for (int i = 0; i < NA; i++) cred_a[i] = 0;
    for (int i = 0; i < NB; i++) cred_b[i] = 0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_ack_in", ack_a, 0);
    check("rst_out_req", oreq_a, 0);
    check("rst_out_addr", oaddr_a, 0);
    check("rst_busy", busy_a, 0);
    check("rst_b_out_req", oreq_b, 0);
    @(negedge clk);
    rst = 1'b0;

    // Single request, manual handshake with 3-cycle responder
    @(negedge clk);
    req_a[5] = 1'b1;
    edges = 0;
    while (!oreq_a && edges < 20) begin @(posedge clk); #1; edges++; end
    check("latency_edges", edges, 3);
    check("single_out_addr", oaddr_a, 5);
    check("single_busy", busy_a, 1);
    repeat (3) @(posedge clk);
    #1 oack_a = 1'b1;
    edges = 0;
    while (!ack_a[5] && edges < 20) begin @(posedge clk); #1; edges++; end
    check("ack5_rise", ack_a, 32'h20);
    check("out_req_low_at_ack", oreq_a, 0);
    repeat (3) @(posedge clk);
    #1 oack_a = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    check("ack5_held_while_req", ack_a, 32'h20);
    req_a[5] = 1'b0;
    edges = 0;
    while (ack_a != '0 && edges < 20) begin @(posedge clk); #1; edges++; end
    check("ack5_fall", ack_a, 0);
    check("busy_after_return", busy_a, 0);

    // Table-driven grant orders
    for (int e = 0; e < 7; e++) begin
      if (tab[e].do_reset) do_reset();
      base = glog_a.size();
      for (int j = 0; j < NA; j++) if (tab[e].mask[j]) cred_a[j] = 1;
      wait_grants(base + tab[e].n, glog_b.size(), 2000, $sformatf("tab%0d", e));
      wait_idle(500, $sformatf("tab%0d", e));
      check($sformatf("tab%0d_count", e), glog_a.size() - base, tab[e].n);
      for (int i = 0; i < tab[e].n; i++)
        check($sformatf("tab%0d_grant%0d", e, i),
              (glog_a.size() > base + i) ? glog_a[base + i] : -1, tab[e].exp[i]);
    end

    // Loser drops its request before being granted (ptr=3 now)
    base = glog_a.size();
    cred_a[4] = 1; cred_a[5] = 1;
    for (int i = 0; i < 200 && !oreq_a; i++) cycle();
    check("drop_first_addr", oaddr_a, 4);
    kill_a = 32'h20;
    wait_idle(500, "drop");
    kill_a = '0;
    check("drop_grant_count", glog_a.size() - base, 1);
    cred_a[5] = 1;
    wait_grants(base + 2, glog_b.size(), 500, "after_drop");
    check("after_drop_grant", (glog_a.size() > base + 1) ? glog_a[base + 1] : -1, 5);
    wait_idle(500, "after_drop");

    // Reset mid-SEND, then mid-RETURN
    @(negedge clk);
    req_a[9] = 1'b1;
    for (int i = 0; i < 20 && !oreq_a; i++) @(negedge clk);
    check("midsend_out_req_up", oreq_a, 1);
    rst = 1'b1;
    #1;
    check("midsend_rst_out_req", oreq_a, 0);
    check("midsend_rst_ack", ack_a, 0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 20 && !oreq_a; i++) @(negedge clk);
    oack_a = 1'b1;
    for (int i = 0; i < 20 && ack_a == '0; i++) @(negedge clk);
    check("midret_ack_up", ack_a, 32'h200);
    rst = 1'b1;
    #1;
    check("midret_rst_ack", ack_a, 0);
    req_a = '0; oack_a = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    check("post_rst_busy", busy_a, 0);

    // All requesters continuously active, both widths
    do_reset();
    base = glog_a.size(); base_b = glog_b.size();
    for (int i = 0; i < NA; i++) cred_a[i] = 2;
    for (int i = 0; i < NB; i++) cred_b[i] = 2;
    wait_grants(base + 64, base_b + 10, 20000, "all");
    for (int i = 0; i < 64; i++)
      check($sformatf("all32_grant%0d", i),
            (glog_a.size() > base + i) ? glog_a[base + i] : -1, i % NA);
    for (int i = 0; i < 10; i++)
      check($sformatf("all5_grant%0d", i),
            (glog_b.size() > base_b + i) ? glog_b[base_b + i] : -1, i % NB);
    dups = 0;
    for (int w = base; w + NA <= glog_a.size(); w++) begin
      seen = '0;
      for (int i = w; i < w + NA; i++) begin
        if (seen[glog_a[i]]) dups++;
        seen[glog_a[i]] = 1'b1;
      end
    end
    check("all32_no_repeat_window", dups, 0);
    wait_idle(2000, "all");

    // Randomised request sets against a modular-scan reference
    do_reset();
    mptr = 0;
    for (int r = 0; r < 20; r++) begin
      mask = $urandom() & $urandom();
      mask[$urandom_range(31, 0)] = 1'b1;
      resp_dly = $urandom_range(5, 1);
      expq.delete();
      pending = mask;
      while (pending != '0) begin
        for (int off = 0; off < NA; off++) begin
          k = (mptr + off) % NA;
          if (pending[k]) begin
            expq.push_back(k);
            pending[k] = 1'b0;
            mptr = (k + 1) % NA;
            break;
          end
        end
      end
      base = glog_a.size();
      for (int j = 0; j < NA; j++) if (mask[j]) cred_a[j] = 1;
      wait_grants(base + expq.size(), glog_b.size(), 4000, $sformatf("rnd%0d", r));
      wait_idle(500, $sformatf("rnd%0d", r));
      check($sformatf("rnd%0d_count", r), glog_a.size() - base, expq.size());
      for (int i = 0; i < expq.size(); i++)
        check($sformatf("rnd%0d_grant%0d", r, i),
              (glog_a.size() > base + i) ? glog_a[base + i] : -1, expq[i]);
    end
    resp_dly = 3;

    check("invariants_n32", viol_a, 0);
    check("invariants_n5", viol_b, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/aer_rr_scheduler.md
Name: aer_rr_scheduler

Overview:
- Clocked scheduler that shares one address-event output channel among N neuron spike requesters.
- Each requester raises a 4-phase req.
- The block grants requesters in round-robin order and emits the winner index on a bundled-data 4-phase output channel (out_req/out_ack).
- It acks the winner only after the output transaction completes.
- It replaces the unfair cascaded-MUTEX priority and provides the ack return path to the firing entry, which the MUTEX cascade lacks.

Parameters:
- N, 32, number of requesters (N >= 2).
- ADDR_W, $clog2(N), width of emitted event address.
- SYNC_STAGES, 2, flip-flop stages on every asynchronous input (req_in, out_ack); minimum 2.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-high reset.
- req_in  input  N  per-requester 4-phase request (asynchronous to clk).
- ack_in  output  N  per-requester 4-phase acknowledge.
- out_req  output  1  output channel request.
- out_addr  output  ADDR_W  index of granted requester, bundled with out_req.
- out_ack  input  1  output channel acknowledge (asynchronous to clk).
- busy  output  1  high whenever state != IDLE.

Behaviour:
- One clock. Reset is asynchronous and active-high.
- Reset values: ack_in=0, out_req=0, out_addr=0, busy=0, ptr=0, state=IDLE, all synchroniser flops=0. Reset takes effect immediately and mid-transaction; the handshake is abandoned with no ack pulse.
- req_in and out_ack each pass through SYNC_STAGES flops. All decisions use the synchronised values only (req_s, ack_s).
- States: IDLE, SEND, RETURN.
- IDLE:
  - If req_s != 0, win = first set index scanning ptr, ptr+1, ..., N-1, 0, ..., ptr-1.
  - Register out_addr=win and out_req=1, then go to SEND.
  - Latency from req_in rising (no contention) to out_req rising: SYNC_STAGES+1 clk edges.
- SEND:
  - out_req=1. out_addr is held stable and does not change while out_req=1.
  - On ack_s=1: out_req=0, ack_in[win]=1, go to RETURN.
- RETURN:
  - Wait until ack_s=0 AND req_s[win]=0.
  - Then ack_in[win]=0, ptr = (win==N-1) ? 0 : win+1, go to IDLE.
- Back-to-back grants: the next grant is evaluated in the cycle after RETURN exits. Minimum 1 IDLE cycle between transactions.
- Invariants:
  - ack_in is one-hot-or-zero.
  - ack_in[k] rises only when k==out_addr of the just-completed transaction.
  - out_req and any ack_in bit are never both high in the same cycle.
- Simultaneous requests: exactly one is granted per transaction, chosen by the ptr scan. A requester holding req waits at most N-1 other grants (fairness bound).
- Requests arriving during SEND/RETURN are not lost. They stay pending on req_in and are considered at the next IDLE.
- A requester that drops req before it is granted is simply not granted. This is protocol-illegal but must not deadlock.
- out_addr values are always < N, including for non-power-of-2 N.
- Wrap-around: a grant to index N-1 sets ptr=0.

Decomposition:
- Package aer_pkg:
  - typedef enum logic [1:0] {IDLE, SEND, RETURN} aer_state_t.
  - Constant DEFAULT_N=32.
  - Function addr_w(n) returning $clog2(n).
- Sub-module rr_pick (combinational, parameter N):
  - Inputs: req[N-1:0], ptr[ADDR_W-1:0].
  - Outputs: valid, idx[ADDR_W-1:0].
  - Implemented as a double-width masked priority encoder.
- Synchroniser flops live inline in aer_rr_scheduler.

Test Plan:
- Reset → all outputs 0. Assert rst during SEND with out_req=1 → out_req and ack_in drop immediately. After release with no req, busy=0.
- Single req_in[5] rising, out_ack responding 3 cycles after each out_req edge:
  - out_req rises 3 edges after req_in (SYNC_STAGES=2).
  - out_addr=5; ack_in[5] rises after out_ack; ack_in[5] falls after req_in[5] and out_ack both drop.
  - ptr=6 afterwards.
- req_in[3], req_in[10], req_in[20] held simultaneously from reset (ptr=0) → grant order 3, 10, 20 with one ack per transaction. Next re-request of 3 and 20 with ptr=21 → order 3, 20.
- All 32 req high continuously, each re-raised after its ack completes → grants cycle 0..31 then 0 again. No index is granted twice within any 32 consecutive grants.
- Grant index 31 → ptr wraps to 0. With req 0 and 31 pending next, 0 wins.
- N=5 build, all req high → out_addr sequence 0, 1, 2, 3, 4, 0. out_addr never ≥5. Assertions: ack_in onehot0; out_addr stable while out_req.
